rf_wb_arbiter: RTL

Shares the register file's single write port among NUM_REQ writeback requesters (ALU, LSU, MUL/DIV, CSR) with round-robin arbitration. Each requester presents a valid/ready writeback; one winner per cycle is registered and driven onto the register file's write port (RegWrite_En, rd, Write_Data) one cycle later. Sits between the execute/writeback units and the register file.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rr_picker.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file writeback arbiter.
//   - default geometry (requester count, register index width, data width)
//   - requester-index type and the named requester slots
package rf_pkg;

    localparam int RF_NUM_REQ = 4;
    localparam int RF_ADDR_W  = 5;
    localparam int RF_DATA_W  = 32;

    localparam int RF_REQ_IDX_W = $clog2(RF_NUM_REQ);

    typedef logic [RF_REQ_IDX_W-1:0] req_idx_t;

    localparam req_idx_t REQ_ALU = req_idx_t'(0);
    localparam req_idx_t REQ_LSU = req_idx_t'(1);
    localparam req_idx_t REQ_MUL = req_idx_t'(2);
    localparam req_idx_t REQ_CSR = req_idx_t'(3);

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search.
// Starting at ptr and moving upward with wrap, the first set bit of valid wins.
// Ports:
//   valid  in   N      candidate requests
//   ptr    in   IW     search start position (0..N-1)
//   grant  out  N      one-hot-or-zero winner
//   idx    out  IW     index of the winner (0 when none)
//   found  out  1      a winner exists
module rr_picker
    import rf_pkg::*;
#(
    parameter int N = RF_NUM_REQ,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    int              pos;
    logic [IW-1:0]   pos_idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N, so one subtraction is enough to wrap
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            pos_idx = IW'(pos);
            if (!found && valid[pos_idx]) begin
                found        = 1'b1;
                grant[pos_idx] = 1'b1;
                idx          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port among NUM_REQ writeback
// requesters with round-robin arbitration; the winner is registered and
// presented on the write port one cycle after the handshake.
// Build option: RF_WB_X0_DROP_EN -- requests with rd=0 are acknowledged at once
// (outside arbitration and wb_hold) and never produce a write.
// Ports:
//   clk          in   1                  clock
//   reset        in   1                  async active-high reset
//   wb_hold      in   1                  block all grants this cycle
//   req_valid    in   NUM_REQ            per-requester request
//   req_rd       in   NUM_REQ*ADDR_W     packed destination indices
//   req_data     in   NUM_REQ*DATA_W     packed write data
//   req_ready    out  NUM_REQ            grant (combinational)
//   RegWrite_En  out  1                  registered write enable
//   rd           out  ADDR_W             registered destination index
//   Write_Data   out  DATA_W             registered write data
//   grant_id     out  $clog2(NUM_REQ)    registered winner index
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite_En,
    output logic [ADDR_W-1:0]         rd,
    output logic [DATA_W-1:0]         Write_Data,
    output logic [IDX_W-1:0]          grant_id
);

    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] arb_valid;
    logic [NUM_REQ-1:0] drop_ready;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               xfer;
    logic [ADDR_W-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;
    logic [IDX_W-1:0]   ptr_next;

`ifdef RF_WB_X0_DROP_EN
    logic [NUM_REQ-1:0] rd_zero;

    always_comb begin
        rd_zero = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_zero[i] = (req_rd[i*ADDR_W +: ADDR_W] == '0);
        end
    end

    // x0 writes are swallowed here and kept out of the round-robin entirely
    assign drop_ready = req_valid & rd_zero;
    assign arb_valid  = req_valid & ~rd_zero;
`else
    assign drop_ready = '0;
    assign arb_valid  = req_valid;
`endif

    rr_picker #(.N(NUM_REQ)) u_picker (
        .valid (arb_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign xfer      = pick_found & ~wb_hold;
    assign req_ready = reset ? '0 : ((xfer ? pick_grant : '0) | drop_ready);

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                win_rd   = req_rd[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            RegWrite_En <= 1'b0;
            rd          <= '0;
            Write_Data  <= '0;
            grant_id    <= '0;
        end else begin
            RegWrite_En <= xfer;
            if (xfer) begin
                ptr        <= ptr_next;
                rd         <= win_rd;
                Write_Data <= win_data;
                grant_id   <= pick_idx;
            end
        end
    end

endmodule
